// File: rtl/legv8_ctrl_pkg.sv
// Shared types and constants for the multi-cycle LEGv8 control unit.
package legv8_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_I    = 4'd3,
    S_EXEC_ADDR = 4'd4,
    S_MEM_RD    = 4'd5,
    S_MEM_WR    = 4'd6,
    S_WB_ALU    = 4'd7,
    S_WB_MEM    = 4'd8,
    S_EXEC_BR   = 4'd9,
    S_FAULT     = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    C_R, C_I, C_LD, C_ST, C_CBZ, C_CBNZ, C_B, C_ILLEGAL
  } instr_class_t;

  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_PASS_B = 2'b01;
  localparam logic [1:0] ALU_FUNC   = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  OP_B    = 6'b000101;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       iord;
    logic       reg2loc;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       mem2reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control-unit <-> datapath bundle: IR/flags in, per-cycle control strobes out.
interface multicycle_control_fsm_if;
  logic [31:0] instruction;
  logic        mem_ready;
  logic        zero;
  logic        IR_WRITE;
  logic        PC_WRITE;
  logic        PC_SRC;
  logic        IORD;
  logic        REG2LOC;
  logic        ALU_SRC_A;
  logic [1:0]  ALU_SRC_B;
  logic [1:0]  ALU_OP;
  logic        MEM2REG;
  logic        REG_WRITE;
  logic        MEM_READ;
  logic        MEM_WRITE;

  modport master (
    input  instruction, mem_ready, zero,
    output IR_WRITE, PC_WRITE, PC_SRC, IORD, REG2LOC, ALU_SRC_A, ALU_SRC_B,
           ALU_OP, MEM2REG, REG_WRITE, MEM_READ, MEM_WRITE
  );

  modport slave (
    output instruction, mem_ready, zero,
    input  IR_WRITE, PC_WRITE, PC_SRC, IORD, REG2LOC, ALU_SRC_A, ALU_SRC_B,
           ALU_OP, MEM2REG, REG_WRITE, MEM_READ, MEM_WRITE
  );
endinterface

// File: rtl/legv8_opcode_decode.sv
// Combinational opcode classifier; shorter opcode fields win (B, CBZ/CBNZ, ADDI, then 11-bit).
module legv8_opcode_decode
  import legv8_ctrl_pkg::*;
(
  input  logic [31:0]  instruction,
  output instr_class_t iclass
);

  logic unused_operand_bits;
  assign unused_operand_bits = ^instruction[20:0];

  always_comb begin
    iclass = C_ILLEGAL;
    if (instruction[31:26] == OP_B)            iclass = C_B;
    else if (instruction[31:24] == OP_CBZ)     iclass = C_CBZ;
    else if (instruction[31:24] == OP_CBNZ)    iclass = C_CBNZ;
    else if (instruction[31:22] == OP_ADDI)    iclass = C_I;
    else begin
      unique case (instruction[31:21])
        OP_ADD, OP_SUB, OP_AND, OP_ORR: iclass = C_R;
        OP_LDUR:                        iclass = C_LD;
        OP_STUR:                        iclass = C_ST;
        default:                        iclass = C_ILLEGAL;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle LEGv8 control FSM with memory-wait timeout and sticky fault.
module multicycle_control_fsm
  import legv8_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT     = 15,
  parameter int HALT_ON_ILLEGAL = 1,
  parameter int TMO_W           = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_control_fsm_if.master ctl,
  output logic                   fault,
  output logic [3:0]             state_o
);

  state_t             state, state_nx;
  instr_class_t       iclass;
  ctrl_t              c, co;
  logic [TMO_W-1:0]   tmo_cnt;
  logic               fault_q;
  logic               wait_st, tmo_hit;

  legv8_opcode_decode u_dec (
    .instruction (ctl.instruction),
    .iclass      (iclass)
  );

  assign wait_st = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
  // Ready on the limit cycle takes precedence: tmo_hit only matters when mem_ready is low.
  assign tmo_hit = (MEM_TIMEOUT != 0) && (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      tmo_cnt <= '0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_nx;
      tmo_cnt <= (wait_st && !ctl.mem_ready) ? tmo_cnt + TMO_W'(1) : '0;
      fault_q <= fault_q | (state_nx == S_FAULT);
    end
  end

  always_comb begin
    c        = '0;
    state_nx = state;
    unique case (state)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        if (ctl.mem_ready) begin
          c.ir_write = 1'b1;
          c.pc_write = 1'b1;
          state_nx   = S_DECODE;
        end else if (tmo_hit) state_nx = S_FAULT;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH2;
        c.alu_op    = ALU_ADD;
        c.reg2loc   = (iclass == C_ST) || (iclass == C_CBZ) || (iclass == C_CBNZ);
        unique case (iclass)
          C_R:               state_nx = S_EXEC_R;
          C_I:               state_nx = S_EXEC_I;
          C_LD, C_ST:        state_nx = S_EXEC_ADDR;
          C_CBZ, C_CBNZ, C_B: state_nx = S_EXEC_BR;
          default:           state_nx = (HALT_ON_ILLEGAL != 0) ? S_FAULT : S_FETCH;
        endcase
      end
      S_EXEC_R: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_REG;
        c.alu_op    = ALU_FUNC;
        state_nx    = S_WB_ALU;
      end
      S_EXEC_I: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
        state_nx    = S_WB_ALU;
      end
      S_EXEC_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
        state_nx    = (iclass == C_ST) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
        if (ctl.mem_ready) state_nx = S_WB_MEM;
        else if (tmo_hit)  state_nx = S_FAULT;
      end
      S_MEM_WR: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
        c.reg2loc   = 1'b1;
        if (ctl.mem_ready) state_nx = S_FETCH;
        else if (tmo_hit)  state_nx = S_FAULT;
      end
      S_WB_ALU: begin
        c.reg_write = 1'b1;
        state_nx    = S_FETCH;
      end
      S_WB_MEM: begin
        c.reg_write = 1'b1;
        c.mem2reg   = 1'b1;
        state_nx    = S_FETCH;
      end
      S_EXEC_BR: begin
        c.pc_src = 1'b1;
        if (iclass == C_B) c.pc_write = 1'b1;
        else begin
          c.reg2loc   = 1'b1;
          c.alu_src_a = 1'b1;
          c.alu_src_b = SRCB_REG;
          c.alu_op    = ALU_PASS_B;
          c.pc_write  = (iclass == C_CBZ) ? ctl.zero : !ctl.zero;
        end
        state_nx = S_FETCH;
      end
      S_FAULT: state_nx = S_FAULT;
      default: state_nx = S_FAULT;
    endcase
  end

  // Gate with rst_n so strobes drop the instant reset asserts, not at the next edge.
  assign co = rst_n ? c : '0;

  assign ctl.IR_WRITE  = co.ir_write;
  assign ctl.PC_WRITE  = co.pc_write;
  assign ctl.PC_SRC    = co.pc_src;
  assign ctl.IORD      = co.iord;
  assign ctl.REG2LOC   = co.reg2loc;
  assign ctl.ALU_SRC_A = co.alu_src_a;
  assign ctl.ALU_SRC_B = co.alu_src_b;
  assign ctl.ALU_OP    = co.alu_op;
  assign ctl.MEM2REG   = co.mem2reg;
  assign ctl.REG_WRITE = co.reg_write;
  assign ctl.MEM_READ  = co.mem_read;
  assign ctl.MEM_WRITE = co.mem_write;

  assign fault   = rst_n & fault_q;
  assign state_o = rst_n ? state : 4'd0;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench: expected per-cycle state/controls queued at drive time, compared on negedge capture.
module tb_multicycle_control_fsm;
  import legv8_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_control_fsm_if ifc ();
  multicycle_control_fsm_if if_nh ();
  logic       fault, fault_nh;
  logic [3:0] state_o, state_nh;

  assign if_nh.instruction = ifc.instruction;
  assign if_nh.mem_ready   = ifc.mem_ready;
  assign if_nh.zero        = ifc.zero;

  multicycle_control_fsm u_dut (
    .clk(clk), .rst_n(rst_n), .ctl(ifc), .fault(fault), .state_o(state_o)
  );

  multicycle_control_fsm #(.HALT_ON_ILLEGAL(0)) u_dut_nh (
    .clk(clk), .rst_n(rst_n), .ctl(if_nh), .fault(fault_nh), .state_o(state_nh)
  );

  // {IR_WRITE,PC_WRITE,PC_SRC,IORD,REG2LOC,ALU_SRC_A,ALU_SRC_B,ALU_OP,MEM2REG,REG_WRITE,MEM_READ,MEM_WRITE,fault}
  logic [14:0] outs;
  assign outs = {ifc.IR_WRITE, ifc.PC_WRITE, ifc.PC_SRC, ifc.IORD, ifc.REG2LOC, ifc.ALU_SRC_A,
                 ifc.ALU_SRC_B, ifc.ALU_OP, ifc.MEM2REG, ifc.REG_WRITE, ifc.MEM_READ,
                 ifc.MEM_WRITE, fault};

  localparam logic [14:0] O_FETCH_WAIT = 15'h0084;
  localparam logic [14:0] O_FETCH_RDY  = 15'h6084;
  localparam logic [14:0] O_DEC        = 15'h0180;
  localparam logic [14:0] O_DEC_R2L    = 15'h0580;
  localparam logic [14:0] O_EXEC_R     = 15'h0240;
  localparam logic [14:0] O_EXEC_IMM   = 15'h0300;
  localparam logic [14:0] O_MEM_RD     = 15'h0804;
  localparam logic [14:0] O_MEM_WR     = 15'h0C02;
  localparam logic [14:0] O_WB_ALU     = 15'h0008;
  localparam logic [14:0] O_WB_MEM     = 15'h0018;
  localparam logic [14:0] O_BR_TAKEN   = 15'h3620;
  localparam logic [14:0] O_BR_NT      = 15'h1620;
  localparam logic [14:0] O_B          = 15'h3000;
  localparam logic [14:0] O_FAULT      = 15'h0001;

  localparam logic [31:0] I_ADD  = 32'h8B020020;
  localparam logic [31:0] I_LDUR = 32'hF8408041;
  localparam logic [31:0] I_STUR = 32'hF8008041;
  localparam logic [31:0] I_CBNZ = 32'hB5000040;
  localparam logic [31:0] I_ADDI = 32'h91000421;
  localparam logic [31:0] I_B    = 32'h14000010;
  localparam logic [31:0] I_BAD  = 32'hFFFFFFFF;

  typedef struct {
    logic [3:0]  st;
    logic [14:0] o;
    string       nm;
  } rec_t;

  rec_t exp_q[$];
  rec_t act_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic drive(input logic rdy, input logic z, input state_t es, input logic [14:0] eo,
                       input string nm);
    rec_t e, a;
    ifc.mem_ready = rdy;
    ifc.zero      = z;
    e.st = es; e.o = eo; e.nm = nm;
    exp_q.push_back(e);
    @(negedge clk);
    a.st = state_o; a.o = outs; a.nm = nm;
    act_q.push_back(a);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    ifc.mem_ready = 1'b0;
    ifc.zero = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ifc.mem_ready = 1'b1;
    ifc.instruction = I_ADD;
    ifc.zero = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (outs !== 15'h0 || state_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs: got out=%h st=%0d, want out=0 st=0", outs, state_o);
    end
    do_reset();
    drive(0, 0, S_FETCH, O_FETCH_WAIT, "reset_first_fetch");
    while (exp_q.size() != 0) begin
      rec_t e, a;
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a.st !== e.st || a.o !== e.o) begin
        errors++;
        $display("FAIL %s: got st=%0d out=%h, want st=%0d out=%h", e.nm, a.st, a.o, e.st, e.o);
      end
    end
  endtask

  task automatic test_add();
    do_reset();
    ifc.instruction = I_ADD;
    drive(1, 0, S_FETCH,  O_FETCH_RDY, "add_fetch");
    drive(1, 0, S_DECODE, O_DEC,       "add_decode");
    drive(1, 0, S_EXEC_R, O_EXEC_R,    "add_exec");
    drive(1, 0, S_WB_ALU, O_WB_ALU,    "add_wb");
    drive(0, 0, S_FETCH,  O_FETCH_WAIT, "add_next_fetch");
    while (exp_q.size() != 0) begin
      rec_t e, a;
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a.st !== e.st || a.o !== e.o) begin
        errors++;
        $display("FAIL %s: got st=%0d out=%h, want st=%0d out=%h", e.nm, a.st, a.o, e.st, e.o);
      end
    end
  endtask

  task automatic test_ldur_wait();
    do_reset();
    ifc.instruction = I_LDUR;
    drive(1, 0, S_FETCH,     O_FETCH_RDY, "ld_fetch");
    drive(0, 0, S_DECODE,    O_DEC,       "ld_decode");
    drive(0, 0, S_EXEC_ADDR, O_EXEC_IMM,  "ld_addr");
    for (int i = 0; i < 3; i++) drive(0, 0, S_MEM_RD, O_MEM_RD, $sformatf("ld_wait%0d", i));
    drive(1, 0, S_MEM_RD,    O_MEM_RD,    "ld_ready");
    drive(0, 0, S_WB_MEM,    O_WB_MEM,    "ld_wb");
    drive(0, 0, S_FETCH,     O_FETCH_WAIT, "ld_next_fetch");
    while (exp_q.size() != 0) begin
      rec_t e, a;
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a.st !== e.st || a.o !== e.o) begin
        errors++;
        $display("FAIL %s: got st=%0d out=%h, want st=%0d out=%h", e.nm, a.st, a.o, e.st, e.o);
      end
    end
  endtask

  task automatic test_cbnz();
    do_reset();
    ifc.instruction = I_CBNZ;
    drive(1, 0, S_FETCH,   O_FETCH_RDY, "cbnz_t_fetch");
    drive(0, 1, S_DECODE,  O_DEC_R2L,   "cbnz_t_decode");
    drive(0, 0, S_EXEC_BR, O_BR_TAKEN,  "cbnz_taken");
    drive(1, 0, S_FETCH,   O_FETCH_RDY, "cbnz_nt_fetch");
    drive(0, 0, S_DECODE,  O_DEC_R2L,   "cbnz_nt_decode");
    drive(0, 1, S_EXEC_BR, O_BR_NT,     "cbnz_not_taken");
    drive(0, 0, S_FETCH,   O_FETCH_WAIT, "cbnz_next_fetch");
    while (exp_q.size() != 0) begin
      rec_t e, a;
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a.st !== e.st || a.o !== e.o) begin
        errors++;
        $display("FAIL %s: got st=%0d out=%h, want st=%0d out=%h", e.nm, a.st, a.o, e.st, e.o);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ifc.instruction = I_ADDI;
    drive(1, 0, S_FETCH,   O_FETCH_RDY, "addi_fetch");
    drive(0, 0, S_DECODE,  O_DEC,       "addi_decode");
    drive(0, 0, S_EXEC_I,  O_EXEC_IMM,  "addi_exec");
    drive(0, 0, S_WB_ALU,  O_WB_ALU,    "addi_wb");
    ifc.instruction = I_B;
    drive(1, 0, S_FETCH,   O_FETCH_RDY, "b_fetch");
    drive(0, 1, S_DECODE,  O_DEC,       "b_decode");
    drive(0, 1, S_EXEC_BR, O_B,         "b_exec");
    drive(0, 0, S_FETCH,   O_FETCH_WAIT, "b_next_fetch");
    while (exp_q.size() != 0) begin
      rec_t e, a;
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a.st !== e.st || a.o !== e.o) begin
        errors++;
        $display("FAIL %s: got st=%0d out=%h, want st=%0d out=%h", e.nm, a.st, a.o, e.st, e.o);
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    ifc.instruction = I_BAD;
    drive(1, 0, S_FETCH,  O_FETCH_RDY, "bad_fetch");
    drive(0, 0, S_DECODE, O_DEC,       "bad_decode");
    checks++;
    if (state_nh !== 4'(S_FETCH) || fault_nh !== 1'b0 || if_nh.MEM_READ !== 1'b1) begin
      errors++;
      $display("FAIL nohalt_illegal: got st=%0d fault=%b rd=%b, want st=0 fault=0 rd=1",
               state_nh, fault_nh, if_nh.MEM_READ);
    end
    drive(1, 0, S_FAULT, O_FAULT, "bad_fault");
    drive(1, 1, S_FAULT, O_FAULT, "bad_fault_sticky");
    while (exp_q.size() != 0) begin
      rec_t e, a;
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a.st !== e.st || a.o !== e.o) begin
        errors++;
        $display("FAIL %s: got st=%0d out=%h, want st=%0d out=%h", e.nm, a.st, a.o, e.st, e.o);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    ifc.instruction = I_ADD;
    for (int i = 0; i < 15; i++) drive(0, 0, S_FETCH, O_FETCH_WAIT, $sformatf("tmo_wait%0d", i));
    drive(0, 0, S_FAULT, O_FAULT, "tmo_fault");
    drive(1, 0, S_FAULT, O_FAULT, "tmo_fault_sticky");
    do_reset();
    for (int i = 0; i < 14; i++) drive(0, 0, S_FETCH, O_FETCH_WAIT, $sformatf("lim_wait%0d", i));
    drive(1, 0, S_FETCH,  O_FETCH_RDY, "lim_ready_wins");
    drive(0, 0, S_DECODE, O_DEC,       "lim_decode");
    while (exp_q.size() != 0) begin
      rec_t e, a;
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a.st !== e.st || a.o !== e.o) begin
        errors++;
        $display("FAIL %s: got st=%0d out=%h, want st=%0d out=%h", e.nm, a.st, a.o, e.st, e.o);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    ifc.instruction = I_STUR;
    drive(1, 0, S_FETCH,     O_FETCH_RDY, "st_fetch");
    drive(0, 0, S_DECODE,    O_DEC_R2L,   "st_decode");
    drive(0, 0, S_EXEC_ADDR, O_EXEC_IMM,  "st_addr");
    drive(0, 0, S_MEM_WR,    O_MEM_WR,    "st_wait");
    #2;
    checks++;
    if (ifc.MEM_WRITE !== 1'b1) begin
      errors++;
      $display("FAIL st_write_held: got MEM_WRITE=%b, want 1", ifc.MEM_WRITE);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ifc.MEM_WRITE !== 1'b0 || state_o !== 4'd0) begin
      errors++;
      $display("FAIL st_async_drop: got MEM_WRITE=%b st=%0d, want 0 0", ifc.MEM_WRITE, state_o);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(0, 0, S_FETCH, O_FETCH_WAIT, "st_after_reset");
    while (exp_q.size() != 0) begin
      rec_t e, a;
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a.st !== e.st || a.o !== e.o) begin
        errors++;
        $display("FAIL %s: got st=%0d out=%h, want st=%0d out=%h", e.nm, a.st, a.o, e.st, e.o);
      end
    end
  endtask

  initial begin
    ifc.instruction = 32'h0;
    ifc.mem_ready = 1'b0;
    ifc.zero = 1'b0;
    test_reset();
    test_add();
    test_ldur_wait();
    test_cbnz();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_reset_mid_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
